// File: rtl/f3_pkg.sv
// Shared GF(3) definitions for the arithmetic layer.
//   trit_t      : one GF(3) digit, 2-bit encoded
//   F3_*        : trit codes; F3_ILLEGAL is never produced by the datapath
//   f3_sanitize : maps the illegal code onto zero before arithmetic
package f3_pkg;

  typedef logic [1:0] trit_t;

  localparam trit_t F3_ZERO    = 2'b00;
  localparam trit_t F3_ONE     = 2'b01;
  localparam trit_t F3_TWO     = 2'b10;
  localparam trit_t F3_ILLEGAL = 2'b11;

  function automatic trit_t f3_sanitize(trit_t t);
    return (t == F3_ILLEGAL) ? F3_ZERO : t;
  endfunction

endpackage

// File: rtl/f3_sub_trit.sv
// Combinational single-trit GF(3) subtractor: c = (a - b) mod 3.
// Ports:
//   a   in  trit_t  minuend
//   b   in  trit_t  subtrahend
//   c   out trit_t  difference, always a legal code
//   bad out 1       a or b carried the illegal code (treated as zero)
module f3_sub_trit
  import f3_pkg::*;
(
  input  trit_t a,
  input  trit_t b,
  output trit_t c,
  output logic  bad
);

  trit_t a_eff;
  trit_t b_eff;

  assign a_eff = f3_sanitize(a);
  assign b_eff = f3_sanitize(b);
  assign bad   = (a == F3_ILLEGAL) || (b == F3_ILLEGAL);

  always_comb begin
    c = F3_ZERO;
    case ({a_eff, b_eff})
      {F3_ZERO, F3_ZERO}: c = F3_ZERO;
      {F3_ZERO, F3_ONE }: c = F3_TWO;
      {F3_ZERO, F3_TWO }: c = F3_ONE;
      {F3_ONE,  F3_ZERO}: c = F3_ONE;
      {F3_ONE,  F3_ONE }: c = F3_ZERO;
      {F3_ONE,  F3_TWO }: c = F3_TWO;
      {F3_TWO,  F3_ZERO}: c = F3_TWO;
      {F3_TWO,  F3_ONE }: c = F3_ONE;
      {F3_TWO,  F3_TWO }: c = F3_ZERO;
      // Sanitized operands never reach the illegal code.
      default:            c = F3_ZERO;
    endcase
  end

endmodule

// File: rtl/f3_subtractor.sv
// Registered GF(3) vector subtractor: C[i] = (A[i] - B[i]) mod 3, trit-wise, no carries.
// Parameters:
//   M          number of trits per operand (bus width 2*M)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   A/B hold an operand pair this cycle
//   A, B       operands, trit i in bits [2i+1:2i]
//   out_valid  C/err hold the result of the pair accepted on the previous edge
//   C          registered difference
//   err        some input trit of the accepted pair was the illegal code
module f3_subtractor
  import f3_pkg::*;
#(
  parameter int unsigned M = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*M-1:0] A,
  input  logic [2*M-1:0] B,
  output logic           out_valid,
  output logic [2*M-1:0] C,
  output logic           err
);

  logic [2*M-1:0] c_d;
  logic [M-1:0]   bad;

  logic [2*M-1:0] c_q;
  logic           err_q;
  logic           valid_q;

  for (genvar i = 0; i < M; i++) begin : g_trit
    f3_sub_trit u_trit (
      .a  (A[2*i +: 2]),
      .b  (B[2*i +: 2]),
      .c  (c_d[2*i +: 2]),
      .bad(bad[i])
    );
  end

  // Result bank only loads on accepted pairs so it holds across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q     <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        c_q   <= c_d;
        err_q <= |bad;
      end
    end
  end

  assign C         = c_q;
  assign err       = err_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_f3_subtractor.sv
module tb_f3_subtractor;

  logic       clk;
  logic       rst_n;
  logic       iv1, iv4;
  logic [1:0] a1, b1;
  logic [7:0] a4, b4;
  logic       ov1, ov4;
  logic [1:0] c1;
  logic [7:0] c4;
  logic       e1, e4;

  int checks = 0;
  int errors = 0;

  logic [8:0] q1[$];
  logic [8:0] q4[$];

  f3_subtractor #(.M(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .A(a1), .B(b1),
    .out_valid(ov1), .C(c1), .err(e1)
  );

  f3_subtractor #(.M(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .A(a4), .B(b4),
    .out_valid(ov4), .C(c4), .err(e4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: trit values as integers, illegal code counts as 0.
  function automatic int tval(logic [1:0] t);
    return (t == 2'b11) ? 0 : int'(t);
  endfunction

  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, int m);
    logic [7:0] c;
    logic       e;
    c = '0;
    e = 1'b0;
    for (int i = 0; i < m; i++) begin
      int d;
      d = (tval(a[2*i +: 2]) - tval(b[2*i +: 2]) + 3) % 3;
      c[2*i +: 2] = 2'(d);
      if (a[2*i +: 2] == 2'b11 || b[2*i +: 2] == 2'b11) e = 1'b1;
    end
    return {e, c};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop one expectation per presented result.
  always @(negedge clk) begin
    if (ov1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_unexpected_valid: got C=%0h err=%0b expected no output", c1, e1);
      end else begin
        logic [8:0] ex;
        ex = q1.pop_front();
        check("dut1_result", {23'd0, e1, 6'd0, c1}, {23'd0, ex[8], 6'd0, ex[1:0]});
      end
    end
    if (ov4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut4_unexpected_valid: got C=%0h err=%0b expected no output", c4, e4);
      end else begin
        logic [8:0] ex;
        ex = q4.pop_front();
        check("dut4_result", {23'd0, e4, c4}, {23'd0, ex});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int tbl[9] = '{0, 2, 1, 1, 0, 2, 2, 1, 0};

  initial begin
    rst_n = 1'b0;
    iv1 = 1'b0; iv4 = 1'b0;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    #12;
    check("reset_c1", {30'd0, c1}, 32'd0);
    check("reset_c4", {24'd0, c4}, 32'd0);
    check("reset_flags", {28'd0, ov1, e1, ov4, e4}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Exhaustive legal single-trit pairs against the mapping table.
    for (int a = 0; a < 3; a++) begin
      for (int b = 0; b < 3; b++) begin
        iv1 = 1'b1; a1 = 2'(a); b1 = 2'(b);
        q1.push_back({1'b0, 6'd0, 2'(tbl[a*3+b])});
        cyc();
      end
    end
    // Illegal codes: treated as zero, flagged.
    a1 = 2'b11; b1 = 2'b01; q1.push_back({1'b1, 6'd0, 2'b10}); cyc();
    a1 = 2'b10; b1 = 2'b11; q1.push_back({1'b1, 6'd0, 2'b10}); cyc();
    iv1 = 1'b0;

    // Hold: outputs stay put, out_valid low.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_c1", {30'd0, c1}, 32'd2);
      check("hold_err", {31'd0, e1}, 32'd1);
      check("hold_valid", {31'd0, ov1}, 32'd0);
    end

    // Vector example.
    iv4 = 1'b1; a4 = 8'b10_01_00_10; b4 = 8'b01_01_10_00;
    q4.push_back({1'b0, 8'b01_00_01_10});
    cyc();
    // Random back-to-back streaming, illegal codes included.
    for (int n = 0; n < 1000; n++) begin
      a4 = 8'($urandom); b4 = 8'($urandom);
      q4.push_back(model(a4, b4, 4));
      cyc();
    end
    iv4 = 1'b0;
    cyc();
    cyc();

    // Async reset between edges while C1 holds 2.
    check("pre_reset_c1", {30'd0, c1}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_c1", {30'd0, c1}, 32'd0);
    check("async_c4", {24'd0, c4}, 32'd0);
    check("async_flags", {28'd0, ov1, e1, ov4, e4}, 32'd0);
    #2;
    rst_n = 1'b1;
    iv1 = 1'b1; a1 = 2'b01; b1 = 2'b00;
    q1.push_back({1'b0, 6'd0, 2'b01});
    cyc();
    iv1 = 1'b0;
    cyc();
    cyc();

    check("q1_drained", q1.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
